// File: rtl/mdu_divider_if.sv
// mdu_divider_if
// Bundles the pipeline-side handshake and register-file writeback signals of
// the iterative divider.
//   master : pipeline control (drives start/op/operands/rd_addr/flush,
//            observes busy/done and the writeback port)
//   slave  : the divider itself
// Parameters: XLEN (operand width), REG_ADDR_W (register address width).
interface mdu_divider_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) ();
  logic                  start;
  logic [1:0]            op;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;

  modport master (
    output start, op, rs1_val, rs2_val, rd_addr, flush,
    input  busy, done, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_addr, flush,
    output busy, done, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/mdu_divider.sv
// mdu_divider
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU). Radix-2
// restoring division, one quotient bit per cycle, writing one result to the
// register file through the wb_* port.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_divider_if.slave
//          start/op/rs1_val/rs2_val/rd_addr : request, sampled in IDLE only
//          flush                            : abort any in-flight operation
//          busy/done                        : status, done is a 1-cycle pulse
//          wb_en/wb_addr/wb_data            : register-file write port
// Build option: define DIV_FASTPATH_EN to let divide-by-zero and signed
// overflow bypass the iteration and complete one cycle after start.
//
// State | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start
// CALC  | one restoring-division step per cycle, XLEN steps
// DONE  | result on wb_*, done pulses for this single cycle
module mdu_divider #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  mdu_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  is_rem_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       divisor_q;
  logic [XLEN-1:0]       dividend_q;
  logic [XLEN-1:0]       rem_q;
  logic [XLEN-1:0]       quot_q;
  logic                  neg_quot_q;
  logic                  neg_rem_q;
  logic                  dz_q;
  logic                  ovf_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic [XLEN-1:0]       wb_data_q;

  // Request decode on the raw operands
  logic            in_signed;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            in_dz, in_ovf;
  logic            accept;

  assign in_signed = ~bus.op[0];
  assign rs1_neg   = in_signed & bus.rs1_val[XLEN-1];
  assign rs2_neg   = in_signed & bus.rs2_val[XLEN-1];
  assign rs1_mag   = rs1_neg ? (-bus.rs1_val) : bus.rs1_val;
  assign rs2_mag   = rs2_neg ? (-bus.rs2_val) : bus.rs2_val;
  assign in_dz     = (bus.rs2_val == '0);
  assign in_ovf    = in_signed && (bus.rs1_val == INT_MIN) && (bus.rs2_val == '1);
  assign accept    = bus.start && !bus.flush;

  // One restoring step. rem_q < divisor, so the shifted remainder is below
  // 2*divisor and the top bit of the XLEN+1 wide difference is a clean
  // borrow flag.
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quot_nx;

  assign rem_sh  = {rem_q, quot_q[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, divisor_q};
  assign ge      = ~rem_sub[XLEN];
  assign rem_nx  = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_nx = {quot_q[XLEN-2:0], ge};

  // Sign fix-up plus the RISC-V defined corner cases. The iteration result
  // is meaningless for a zero divisor, so those flags override it.
  function automatic logic [XLEN-1:0] final_result(
    input logic            is_rem,
    input logic [XLEN-1:0] quot,
    input logic [XLEN-1:0] rem,
    input logic            neg_q,
    input logic            neg_r,
    input logic            dz,
    input logic            ovf,
    input logic [XLEN-1:0] dividend
  );
    if (dz)     return is_rem ? dividend : '1;
    if (ovf)    return is_rem ? '0 : INT_MIN;
    if (is_rem) return neg_r ? (-rem) : rem;
    return neg_q ? (-quot) : quot;
  endfunction

  logic                  load_wb;
  logic [REG_ADDR_W-1:0] wb_addr_d;
  logic [XLEN-1:0]       wb_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_wb   = 1'b0;
    wb_addr_d = rd_q;
    wb_data_d = final_result(is_rem_q, quot_nx, rem_nx, neg_quot_q, neg_rem_q,
                             dz_q, ovf_q, dividend_q);
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_FASTPATH_EN
          if (in_dz || in_ovf) begin
            state_d   = S_DONE;
            load_wb   = 1'b1;
            wb_addr_d = bus.rd_addr;
            wb_data_d = final_result(bus.op[1], '0, '0, 1'b0, 1'b0,
                                     in_dz, in_ovf, bus.rs1_val);
          end else begin
            state_d = S_CALC;
          end
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          load_wb = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort never reaches DONE and never touches the writeback registers
    if (bus.flush) begin
      state_d = S_IDLE;
      load_wb = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      if (state_q == S_IDLE && accept) begin
        cnt_q      <= '0;
        is_rem_q   <= bus.op[1];
        rd_q       <= bus.rd_addr;
        divisor_q  <= rs2_mag;
        dividend_q <= bus.rs1_val;
        rem_q      <= '0;
        quot_q     <= rs1_mag;
        neg_quot_q <= rs1_neg ^ rs2_neg;
        neg_rem_q  <= rs1_neg;
        dz_q       <= in_dz;
        ovf_q      <= in_ovf;
      end else if (state_q == S_CALC) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        rem_q  <= rem_nx;
        quot_q <= quot_nx;
      end
      if (load_wb) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
      end
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.wb_en   = (state_q == S_DONE) && (wb_addr_q != '0);
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule
